morse_round_ctrl: RTL and testbench

- Game-round controller that sits directly downstream of the ten-second timer and consumes its timeout.
- Starts and enables the timer for each round, times key presses with the 1 ms tick, and classifies each press as dot or dash.
- Compares each symbol against the expected pattern read from the letter ROM, then declares win or lose.
- On a win, advances the ROM address and the score.

---
 rtl/morse_round_ctrl.sv | 160 ++++++++++++++++
 tb/tb_morse_round_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_round_ctrl.sv
// Morse game-round controller: runs the round timer, times key presses into dots/dashes,
// checks them against the letter ROM and scores wins. Optional MORSE_RETRY_EN adds retry-on-mismatch.
module morse_round_ctrl #(
    parameter int MAX_SYM = 5,
    parameter int DASH_MS = 300,
    parameter int MIN_MS  = 20,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ms_tick,
    input  logic               key,
    input  logic               timeout,
    input  logic [MAX_SYM-1:0] exp_pattern,
    input  logic [2:0]         exp_len,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               timer_en,
    output logic               timer_clr_n,
    output logic               busy,
    output logic               win,
    output logic               lose,
    output logic [7:0]         score,
    output logic [2:0]         sym_cnt,
`ifdef MORSE_RETRY_EN
    output logic               retry_pulse,
`endif
    output logic [2:0]         state_dbg
);

    localparam int MS_W = $clog2(DASH_MS + 1);
    localparam logic [MS_W-1:0] DASH_V = MS_W'(DASH_MS);
    localparam logic [MS_W-1:0] MIN_V  = MS_W'(MIN_MS);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        WAIT_PRESS = 3'd2,
        PRESSED    = 3'd3,
        CHECK      = 3'd4,
        WIN        = 3'd5,
        LOSE       = 3'd6
    } state_t;

    state_t            state, state_n;
    logic [MS_W-1:0]   press_ms, press_ms_n;
    logic              armed, armed_n;
    logic [2:0]        sym_cnt_n;
    logic [7:0]        score_n;
    logic [ADDR_W-1:0] rom_addr_n;
    logic [2:0]        next_cnt;
    logic [MAX_SYM-1:0] pat_shift;
    logic              exp_bit;
    logic              is_dash;
`ifdef MORSE_RETRY_EN
    logic              retry_n;
`endif

    // Out-of-range symbol index shifts in zeros, so an over-long exp_len expects dots.
    assign pat_shift = exp_pattern >> sym_cnt;
    assign exp_bit   = pat_shift[0];
    assign is_dash   = (press_ms >= DASH_V);
    assign next_cnt  = sym_cnt + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            press_ms <= '0;
            armed    <= 1'b0;
            sym_cnt  <= 3'd0;
            score    <= 8'd0;
            rom_addr <= '0;
`ifdef MORSE_RETRY_EN
            retry_pulse <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            press_ms <= press_ms_n;
            armed    <= armed_n;
            sym_cnt  <= sym_cnt_n;
            score    <= score_n;
            rom_addr <= rom_addr_n;
`ifdef MORSE_RETRY_EN
            retry_pulse <= retry_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        press_ms_n = press_ms;
        armed_n    = armed;
        sym_cnt_n  = sym_cnt;
        score_n    = score;
        rom_addr_n = rom_addr;
`ifdef MORSE_RETRY_EN
        retry_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) state_n = CLEAR;
            end
            CLEAR: begin
                sym_cnt_n = 3'd0;
                // A key already down at round start must be released before it counts.
                armed_n   = ~key;
                state_n   = (exp_len == 3'd0) ? CHECK : WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (timeout) begin
                    state_n = LOSE;
                end else if (!key) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    press_ms_n = '0;
                    state_n    = PRESSED;
                end
            end
            PRESSED: begin
                if (timeout) begin
                    state_n = LOSE;
                end else if (!key) begin
                    if (press_ms < MIN_V) begin
                        state_n = WAIT_PRESS;
                    end else if (is_dash == exp_bit) begin
                        sym_cnt_n = next_cnt;
                        state_n   = (next_cnt == exp_len) ? CHECK : WAIT_PRESS;
                    end else begin
`ifdef MORSE_RETRY_EN
                        sym_cnt_n = 3'd0;
                        armed_n   = 1'b0;
                        retry_n   = 1'b1;
                        state_n   = WAIT_PRESS;
`else
                        state_n   = LOSE;
`endif
                    end
                end else if (ms_tick && press_ms != DASH_V) begin
                    press_ms_n = press_ms + MS_W'(1);
                end
            end
            CHECK: state_n = WIN;
            WIN: begin
                if (score != 8'hFF) score_n = score + 8'd1;
                rom_addr_n = rom_addr + ADDR_W'(1);
                state_n    = IDLE;
            end
            LOSE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign timer_en    = (state == WAIT_PRESS) || (state == PRESSED);
    assign timer_clr_n = (state != CLEAR);
    assign busy        = (state != IDLE);
    assign win         = (state == WIN);
    assign lose        = (state == LOSE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Directed bench for morse_round_ctrl: table of letter rounds with hand-computed outcomes
// plus hand-written timeout, held-key, reset and score-saturation sequences.
module tb_morse_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       ms_tick = 1'b0;
    logic       key = 1'b0;
    logic       timeout = 1'b0;
    logic [4:0] exp_pattern = 5'd0;
    logic [2:0] exp_len = 3'd0;
    logic [4:0] rom_addr;
    logic       timer_en;
    logic       timer_clr_n;
    logic       busy;
    logic       win;
    logic       lose;
    logic [7:0] score;
    logic [2:0] sym_cnt;
    logic [2:0] state_dbg;
`ifdef MORSE_RETRY_EN
    logic       retry_pulse;
`endif

    int checks = 0;
    int failures = 0;

    morse_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .ms_tick(ms_tick), .key(key),
        .timeout(timeout), .exp_pattern(exp_pattern), .exp_len(exp_len),
        .rom_addr(rom_addr), .timer_en(timer_en), .timer_clr_n(timer_clr_n),
        .busy(busy), .win(win), .lose(lose), .score(score), .sym_cnt(sym_cnt),
`ifdef MORSE_RETRY_EN
        .retry_pulse(retry_pulse),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] pat;
        logic [2:0] len;
        int         np;
        int         dur [5];
        bit         exp_win;
        logic [2:0] exp_cnt;
        logic [7:0] exp_score;
        logic [4:0] exp_addr;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic [4:0] pat, input logic [2:0] len, input int np,
                                input int d0, input int d1, input int d2, input int d3, input int d4,
                                input bit w, input logic [2:0] c, input logic [7:0] s, input logic [4:0] a);
        vec_t v;
        v.pat = pat; v.len = len; v.np = np;
        v.dur[0] = d0; v.dur[1] = d1; v.dur[2] = d2; v.dur[3] = d3; v.dur[4] = d4;
        v.exp_win = w; v.exp_cnt = c; v.exp_score = s; v.exp_addr = a;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ms_tick = 1'b1;
            step();
            ms_tick = 1'b0;
            step();
        end
    endtask

    // Press for exactly d counted ticks; returns one sample after the release edge.
    task automatic press(input int d);
        key = 1'b1;
        step();
        hold_ticks(d);
        key = 1'b0;
        step();
    endtask

    task automatic start_round(input logic [4:0] pat, input logic [2:0] len);
        exp_pattern = pat;
        exp_len = len;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clear_clr_n", timer_clr_n, 0);
        chk("clear_busy", busy, 1);
        chk("clear_timer_en", timer_en, 0);
        step();
        if (len != 3'd0) begin
            chk("wait_timer_en", timer_en, 1);
            chk("wait_clr_n", timer_clr_n, 1);
            chk("wait_sym_cnt", sym_cnt, 0);
        end
    endtask

    // Watches five samples and reports the first cycle each pulse appears (-1 = never).
    task automatic wait_result(output int cw, output int cl, output int cr, output int cnt0);
        cw = -1; cl = -1; cr = -1;
        cnt0 = int'(sym_cnt);
        for (int c = 0; c < 5; c++) begin
            if (win && cw < 0) cw = c;
            if (lose && cl < 0) cl = c;
`ifdef MORSE_RETRY_EN
            if (retry_pulse && cr < 0) cr = c;
`endif
            if (win && lose) chk("win_and_lose", 1, 0);
            step();
        end
    endtask

    initial begin
        int cw, cl, cr, cnt0;

        vecs[0]  = mk(5'b00010, 3'd2, 2, 100, 400, 0, 0, 0, 1'b1, 3'd2, 8'd1, 5'd1);
        vecs[1]  = mk(5'b00010, 3'd2, 1, 400, 0, 0, 0, 0, 1'b0, 3'd0, 8'd1, 5'd1);
        vecs[2]  = mk(5'b00000, 3'd1, 2, 10, 100, 0, 0, 0, 1'b1, 3'd1, 8'd2, 5'd2);
        vecs[3]  = mk(5'b00000, 3'd1, 2, 19, 20, 0, 0, 0, 1'b1, 3'd1, 8'd3, 5'd3);
        vecs[4]  = mk(5'b00000, 3'd1, 1, 299, 0, 0, 0, 0, 1'b1, 3'd1, 8'd4, 5'd4);
        vecs[5]  = mk(5'b00001, 3'd1, 1, 300, 0, 0, 0, 0, 1'b1, 3'd1, 8'd5, 5'd5);
        vecs[6]  = mk(5'b00001, 3'd1, 1, 299, 0, 0, 0, 0, 1'b0, 3'd0, 8'd5, 5'd5);
        vecs[7]  = mk(5'b00000, 3'd2, 2, 20, 300, 0, 0, 0, 1'b0, 3'd1, 8'd5, 5'd5);
        vecs[8]  = mk(5'b11111, 3'd0, 0, 0, 0, 0, 0, 0, 1'b1, 3'd0, 8'd6, 5'd6);
        vecs[9]  = mk(5'b10101, 3'd5, 5, 300, 20, 300, 20, 300, 1'b1, 3'd5, 8'd7, 5'd7);
        vecs[10] = mk(5'b00000, 3'd3, 3, 20, 20, 500, 0, 0, 1'b0, 3'd2, 8'd7, 5'd7);

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_timer_en", timer_en, 0);
        chk("rst_clr_n", timer_clr_n, 1);
        chk("rst_score", score, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        step();
        rst = 1'b1;
        step();

        for (int r = 0; r < 11; r++) begin
            start_round(vecs[r].pat, vecs[r].len);
            for (int p = 0; p < vecs[r].np; p++) press(vecs[r].dur[p]);
            wait_result(cw, cl, cr, cnt0);
            if (vecs[r].exp_win) begin
                chk($sformatf("v%0d_win_lat", r), cw, 1);
                chk($sformatf("v%0d_no_lose", r), cl, -1);
                chk($sformatf("v%0d_sym_cnt", r), cnt0, vecs[r].exp_cnt);
            end else begin
`ifdef MORSE_RETRY_EN
                chk($sformatf("v%0d_retry", r), cr, 0);
                chk($sformatf("v%0d_no_lose", r), cl, -1);
                chk($sformatf("v%0d_sym_cnt", r), cnt0, 0);
                chk($sformatf("v%0d_still_busy", r), busy, 1);
                timeout = 1'b1;
                step();
                timeout = 1'b0;
                chk($sformatf("v%0d_to_lose", r), lose, 1);
                step();
`else
                chk($sformatf("v%0d_lose_lat", r), cl, 0);
                chk($sformatf("v%0d_no_win", r), cw, -1);
                chk($sformatf("v%0d_sym_cnt", r), cnt0, vecs[r].exp_cnt);
`endif
            end
            chk($sformatf("v%0d_busy", r), busy, 0);
            chk($sformatf("v%0d_timer_en", r), timer_en, 0);
            chk($sformatf("v%0d_score", r), score, vecs[r].exp_score);
            chk($sformatf("v%0d_addr", r), rom_addr, vecs[r].exp_addr);
        end

        // Timeout outside a round does nothing.
        timeout = 1'b1;
        step();
        timeout = 1'b0;
        chk("idle_to_lose", lose, 0);
        chk("idle_to_busy", busy, 0);

        // Ten-second timeout while waiting for a press.
        start_round(5'b00000, 3'd1);
        step(); step(); step();
        timeout = 1'b1;
        step();
        timeout = 1'b0;
        chk("to_lose", lose, 1);
        chk("to_win", win, 0);
        step();
        chk("to_busy", busy, 0);
        chk("to_timer_en", timer_en, 0);
        chk("to_score", score, 7);

        // Key held across start is ignored until released.
        key = 1'b1;
        start_round(5'b00000, 3'd2);
        hold_ticks(50);
        chk("held_state", state_dbg, 2);
        chk("held_sym_cnt", sym_cnt, 0);
        key = 1'b0;
        step();
        press(100);
        chk("held_sym_after", sym_cnt, 1);
        chk("held_state_after", state_dbg, 2);
        chk("held_busy", busy, 1);
        timeout = 1'b1;
        step();
        timeout = 1'b0;
        chk("held_end_lose", lose, 1);
        step();

        // Timeout on the same cycle as the final correct release.
        start_round(5'b00000, 3'd1);
        key = 1'b1;
        step();
        hold_ticks(100);
        key = 1'b0;
        timeout = 1'b1;
        step();
        timeout = 1'b0;
        wait_result(cw, cl, cr, cnt0);
        chk("tie_lose_lat", cl, 0);
        chk("tie_no_win", cw, -1);
        chk("tie_score", score, 7);
        chk("tie_addr", rom_addr, 7);

        // Asynchronous reset in the middle of a press.
        start_round(5'b00000, 3'd1);
        key = 1'b1;
        step();
        hold_ticks(5);
        chk("pre_rst_state", state_dbg, 3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_state", state_dbg, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_timer_en", timer_en, 0);
        chk("mid_rst_clr_n", timer_clr_n, 1);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_sym_cnt", sym_cnt, 0);
        chk("mid_rst_win", win, 0);
        chk("mid_rst_lose", lose, 0);
        key = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);

        // Score saturation and address wrap with zero-length letters.
        exp_len = 3'd0;
        for (int i = 0; i < 255; i++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            step(); step(); step();
        end
        chk("sat_score", score, 255);
        chk("sat_addr", rom_addr, 31);
        start_round(5'b00000, 3'd0);
        wait_result(cw, cl, cr, cnt0);
        chk("sat_win_lat", cw, 1);
        chk("sat_score_hold", score, 255);
        chk("wrap_addr", rom_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
